// File: rtl/imuldiv_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_pkg
// Shared definitions for the mul/div requester and the iterative mul/div unit:
// function codes, message widths and field offsets inside the request message.
// No ports (package).
// ---------------------------------------------------------------------------
package imuldiv_muldiv_pkg;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;

  localparam int REQ_MSG_W  = 67;
  localparam int RESP_MSG_W = 64;

  // Request message layout: {fn[66:64], a[63:32], b[31:0]}
  localparam int REQ_FN_LSB = 64;
  localparam int REQ_A_LSB  = 32;
  localparam int REQ_B_LSB  = 0;

  // Codes above FN_DIVU are reserved and are completed locally with err set.
  function automatic logic fn_reserved(input logic [2:0] fn);
    return fn > FN_DIVU;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_tag_queue.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_tag_queue
// DEPTH-entry synchronous FIFO holding {tag, fn, err} for every accepted
// command until its writeback is loaded. The head entry is presented
// combinationally; a push is honoured while full if a pop happens in the
// same cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data enqueue request and entry
//   pop             dequeue the head (ignored when empty)
//   head_data       current head entry
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module imuldiv_muldiv_tag_queue
  import imuldiv_muldiv_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first so no latch can be inferred; clocked blocks use '<=' only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read
  // after it has been written, and the pointers/count carry all the state.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/imuldiv_muldiv_requester.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_requester
// Front end between issue and the iterative mul/div unit. Accepts tagged
// commands, issues one request at a time, pairs in-order responses with the
// tag queue head and returns tagged writebacks in command order. Reserved
// function codes bypass the unit and write back with err set.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_fn/a/b/tag, cmd_val/rdy        command in
//   muldivreq_msg_fn/a/b, _val/_rdy    request out to the unit
//   muldivresp_msg_result, _val/_rdy   response in from the unit
//   wb_hi/lo/tag/fn/err, wb_val/rdy    writeback out
//   cnt_issued, cnt_done               request and writeback fire counters
// ---------------------------------------------------------------------------
module imuldiv_muldiv_requester
  import imuldiv_muldiv_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            cmd_fn,
  input  logic [31:0]           cmd_a,
  input  logic [31:0]           cmd_b,
  input  logic [TAG_W-1:0]      cmd_tag,
  input  logic                  cmd_val,
  output logic                  cmd_rdy,
  output logic [2:0]            muldivreq_msg_fn,
  output logic [31:0]           muldivreq_msg_a,
  output logic [31:0]           muldivreq_msg_b,
  output logic                  muldivreq_val,
  input  logic                  muldivreq_rdy,
  input  logic [RESP_MSG_W-1:0] muldivresp_msg_result,
  input  logic                  muldivresp_val,
  output logic                  muldivresp_rdy,
  output logic [31:0]           wb_hi,
  output logic [31:0]           wb_lo,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [2:0]            wb_fn,
  output logic                  wb_err,
  output logic                  wb_val,
  input  logic                  wb_rdy,
  output logic [31:0]           cnt_issued,
  output logic [31:0]           cnt_done
);

  localparam int TQ_W = TAG_W + 4;

  logic                 req_full_q, req_full_d;
  logic [REQ_MSG_W-1:0] req_q, req_d;

  logic                 wb_full_q, wb_full_d;
  logic [31:0]          wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
  logic [TAG_W-1:0]     wb_tag_q, wb_tag_d;
  logic [2:0]           wb_fn_q, wb_fn_d;
  logic                 wb_err_q, wb_err_d;

  logic [31:0]          cnt_issued_q, cnt_issued_d, cnt_done_q, cnt_done_d;

  logic [TQ_W-1:0]      tagq_head;
  logic                 tagq_full, tagq_empty;
  logic [TAG_W-1:0]     head_tag;
  logic [2:0]           head_fn;
  logic                 head_err;

  logic cmd_err, cmd_fire, req_fire, resp_fire, wb_fire;
  logic wb_can_load, err_fill, wb_load;

  assign cmd_err  = fn_reserved(cmd_fn);
  assign cmd_rdy  = !req_full_q && !tagq_full;
  assign cmd_fire = cmd_val && cmd_rdy;

  assign muldivreq_val    = req_full_q;
  assign muldivreq_msg_fn = req_q[REQ_FN_LSB +: 3];
  assign muldivreq_msg_a  = req_q[REQ_A_LSB  +: 32];
  assign muldivreq_msg_b  = req_q[REQ_B_LSB  +: 32];
  assign req_fire         = muldivreq_val && muldivreq_rdy;

  assign {head_tag, head_fn, head_err} = tagq_head;

  // The writeback register may refill in the same cycle it drains.
  assign wb_can_load    = !wb_full_q || wb_rdy;
  assign muldivresp_rdy = !tagq_empty && !head_err && wb_can_load;
  assign resp_fire      = muldivresp_val && muldivresp_rdy;
  // Reserved entries complete locally once they reach the head.
  assign err_fill       = !tagq_empty && head_err && wb_can_load;
  assign wb_load        = resp_fire || err_fill;
  assign wb_fire        = wb_full_q && wb_rdy;

  imuldiv_muldiv_tag_queue #(
    .W     (TQ_W),
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_fire),
    .push_data ({cmd_tag, cmd_fn, cmd_err}),
    .pop       (wb_load),
    .head_data (tagq_head),
    .full      (tagq_full),
    .empty     (tagq_empty)
  );

  always_comb begin
    req_full_d   = req_full_q;
    req_d        = req_q;
    wb_full_d    = wb_full_q;
    wb_hi_d      = wb_hi_q;
    wb_lo_d      = wb_lo_q;
    wb_tag_d     = wb_tag_q;
    wb_fn_d      = wb_fn_q;
    wb_err_d     = wb_err_q;
    cnt_issued_d = cnt_issued_q;
    cnt_done_d   = cnt_done_q;

    if (cmd_fire && !cmd_err) begin
      req_full_d = 1'b1;
      req_d      = {cmd_fn, cmd_a, cmd_b};
    end else if (req_fire) begin
      req_full_d = 1'b0;
    end
    if (req_fire) cnt_issued_d = cnt_issued_q + 32'd1;

    if (wb_load) begin
      wb_full_d = 1'b1;
      wb_hi_d   = resp_fire ? muldivresp_msg_result[63:32] : 32'd0;
      wb_lo_d   = resp_fire ? muldivresp_msg_result[31:0]  : 32'd0;
      wb_tag_d  = head_tag;
      wb_fn_d   = head_fn;
      wb_err_d  = head_err;
    end else if (wb_fire) begin
      wb_full_d = 1'b0;
    end
    if (wb_fire) cnt_done_d = cnt_done_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_full_q   <= 1'b0;
      req_q        <= '0;
      wb_full_q    <= 1'b0;
      wb_hi_q      <= '0;
      wb_lo_q      <= '0;
      wb_tag_q     <= '0;
      wb_fn_q      <= '0;
      wb_err_q     <= 1'b0;
      cnt_issued_q <= '0;
      cnt_done_q   <= '0;
    end else begin
      req_full_q   <= req_full_d;
      req_q        <= req_d;
      wb_full_q    <= wb_full_d;
      wb_hi_q      <= wb_hi_d;
      wb_lo_q      <= wb_lo_d;
      wb_tag_q     <= wb_tag_d;
      wb_fn_q      <= wb_fn_d;
      wb_err_q     <= wb_err_d;
      cnt_issued_q <= cnt_issued_d;
      cnt_done_q   <= cnt_done_d;
    end
  end

  assign wb_val     = wb_full_q;
  assign wb_hi      = wb_hi_q;
  assign wb_lo      = wb_lo_q;
  assign wb_tag     = wb_tag_q;
  assign wb_fn      = wb_fn_q;
  assign wb_err     = wb_err_q;
  assign cnt_issued = cnt_issued_q;
  assign cnt_done   = cnt_done_q;

endmodule

// File: tb/tb_imuldiv_muldiv_requester.sv
// ---------------------------------------------------------------------------
// tb_imuldiv_muldiv_requester
// Scoreboard bench: each accepted command pushes its expected writeback; a
// monitor pops and compares on every writeback handshake. A behavioural
// mul/div unit answers requests in order with optional stalls.
// ---------------------------------------------------------------------------
module tb_imuldiv_muldiv_requester;
  import imuldiv_muldiv_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic             clk, reset;
  logic [2:0]       cmd_fn;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             cmd_val, cmd_rdy;
  logic [2:0]       muldivreq_msg_fn;
  logic [31:0]      muldivreq_msg_a, muldivreq_msg_b;
  logic             muldivreq_val, muldivreq_rdy;
  logic [63:0]      muldivresp_msg_result;
  logic             muldivresp_val, muldivresp_rdy;
  logic [31:0]      wb_hi, wb_lo;
  logic [TAG_W-1:0] wb_tag;
  logic [2:0]       wb_fn;
  logic             wb_err, wb_val, wb_rdy;
  logic [31:0]      cnt_issued, cnt_done;

  imuldiv_muldiv_requester #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_fn                (cmd_fn),
    .cmd_a                 (cmd_a),
    .cmd_b                 (cmd_b),
    .cmd_tag               (cmd_tag),
    .cmd_val               (cmd_val),
    .cmd_rdy               (cmd_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_hi                 (wb_hi),
    .wb_lo                 (wb_lo),
    .wb_tag                (wb_tag),
    .wb_fn                 (wb_fn),
    .wb_err                (wb_err),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .cnt_issued            (cnt_issued),
    .cnt_done              (cnt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [TAG_W-1:0] tag;
    logic [2:0]       fn;
    logic             err;
  } wb_t;

  wb_t         sb_q[$];
  logic [63:0] unit_q[$];
  int          errors = 0;
  int          checks = 0;

  // Stall modes: 0 = always ready, 1 = held low, 2 = random.
  int wb_mode   = 0;
  int req_mode  = 0;
  bit resp_hold = 1'b0;
  bit resp_rand = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of the mul/div unit.
  function automatic logic [63:0] unit_result(input logic [2:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (fn)
      FN_MUL:  begin p = longint'(sa) * longint'(sb); return p; end
      FN_DIV:  begin q = sa / sb; r = sa % sb; return {r, q}; end
      FN_DIVU: begin q = a / b;   r = a % b;   return {r, q}; end
      default: return 64'd0;
    endcase
  endfunction

  function automatic wb_t make_exp(input logic [2:0] fn, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
    logic [63:0] res;
    if (fn > FN_DIVU) return '{hi: 32'd0, lo: 32'd0, tag: tag, fn: fn, err: 1'b1};
    res = unit_result(fn, a, b);
    return '{hi: res[63:32], lo: res[31:0], tag: tag, fn: fn, err: 1'b0};
  endfunction

  // Environment: ready/valid stalls and response presentation.
  initial begin
    wb_rdy                = 1'b1;
    muldivreq_rdy         = 1'b1;
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = '0;
    forever begin
      @(negedge clk);
      wb_rdy        = (wb_mode == 0) ? 1'b1 : (wb_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      muldivreq_rdy = (req_mode == 0) ? 1'b1 : (req_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      muldivresp_val = (unit_q.size() > 0) && !resp_hold && (!resp_rand || ($urandom_range(0, 3) != 0));
      muldivresp_msg_result = (unit_q.size() > 0) ? unit_q[0] : 64'd0;
    end
  end

  // Behavioural unit: in-order queue of results.
  always @(posedge clk) begin
    if (reset) begin
      unit_q.delete();
    end else begin
      if (muldivresp_val && muldivresp_rdy && unit_q.size() > 0) void'(unit_q.pop_front());
      if (muldivreq_val && muldivreq_rdy)
        unit_q.push_back(unit_result(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
    end
  end

  // Monitor: compare every writeback handshake against the scoreboard.
  initial begin
    wb_t got, exp;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && wb_val && wb_rdy) begin
        got = '{hi: wb_hi, lo: wb_lo, tag: wb_tag, fn: wb_fn, err: wb_err};
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got %0h expected none", got);
        end else begin
          exp = sb_q.pop_front();
          check("wb", got, exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input wb_t exp);
    int n;
    n = 0;
    @(negedge clk);
    cmd_fn  = fn;
    cmd_a   = a;
    cmd_b   = b;
    cmd_tag = tag;
    cmd_val = 1'b1;
    forever begin
      #4;
      if (cmd_rdy) begin
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL cmd_timeout: got cmd_rdy 0 expected 1 within 300 cycles");
        cmd_val = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || wb_val) && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(name, {sb_q.size() == 0, !wb_val}, 2'b11);
  endtask

  task automatic settle();
    @(negedge clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({pfx, "_req_val"}, muldivreq_val, 1'b0);
    check({pfx, "_resp_rdy"}, muldivresp_rdy, 1'b0);
    check({pfx, "_wb_val"}, wb_val, 1'b0);
    check({pfx, "_wb_fields"}, {wb_hi, wb_lo, wb_tag, wb_fn, wb_err}, '0);
    check({pfx, "_cnt_issued"}, cnt_issued, 32'd0);
    check({pfx, "_cnt_done"}, cnt_done, 32'd0);
  endtask

  initial begin
    logic [31:0] ci0, cd0, ra, rb;
    logic [2:0]  rfn;
    int          r, n_issue;

    reset   = 1'b1;
    cmd_val = 1'b0;
    cmd_fn  = '0;
    cmd_a   = '0;
    cmd_b   = '0;
    cmd_tag = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check_reset_outputs("reset");

    // mul
    send_cmd(3'd0, 32'hfffffff8, 32'h00000008, 5'd3,
             '{hi: 32'hffffffff, lo: 32'hffffffc0, tag: 5'd3, fn: 3'd0, err: 1'b0});
    settle();
    check("mul_req_val", muldivreq_val, 1'b1);
    check("mul_req_msg", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b},
          {3'd0, 32'hfffffff8, 32'h00000008});
    wait_drain("mul_drain");

    // div pair
    send_cmd(3'd1, 32'h0a01b044, 32'hffffb14a, 5'd1,
             '{hi: 32'h00003372, lo: 32'hffffdf75, tag: 5'd1, fn: 3'd1, err: 1'b0});
    send_cmd(3'd2, 32'hfffffff8, 32'h00000008, 5'd2,
             '{hi: 32'h00000000, lo: 32'h1fffffff, tag: 5'd2, fn: 3'd2, err: 1'b0});
    wait_drain("div_drain");

    // reserved latency: accept at N, wb_val at N+2
    send_cmd(3'd6, 32'h1, 32'h2, 5'd9,
             '{hi: 32'd0, lo: 32'd0, tag: 5'd9, fn: 3'd6, err: 1'b1});
    settle();
    check("rsv_wb_val_n1", wb_val, 1'b0);
    settle();
    check("rsv_wb_val_n2", wb_val, 1'b1);
    wait_drain("rsv_drain");

    // reserved between two muls
    ci0 = cnt_issued;
    cd0 = cnt_done;
    send_cmd(3'd0, 32'd7, 32'd6, 5'd1,
             '{hi: 32'd0, lo: 32'd42, tag: 5'd1, fn: 3'd0, err: 1'b0});
    send_cmd(3'd5, 32'h12345678, 32'h9abcdef0, 5'd7,
             '{hi: 32'd0, lo: 32'd0, tag: 5'd7, fn: 3'd5, err: 1'b1});
    send_cmd(3'd0, 32'hffffffff, 32'hffffffff, 5'd2,
             '{hi: 32'd0, lo: 32'd1, tag: 5'd2, fn: 3'd0, err: 1'b0});
    wait_drain("rsv_mid_drain");
    check("rsv_cnt_issued", cnt_issued - ci0, 32'd2);
    check("rsv_cnt_done", cnt_done - cd0, 32'd3);

    // backpressure
    wb_mode   = 1;
    resp_hold = 1'b1;
    send_cmd(3'd0, 32'd2, 32'd3, 5'd4,
             '{hi: 32'd0, lo: 32'd6, tag: 5'd4, fn: 3'd0, err: 1'b0});
    send_cmd(3'd0, 32'd5, 32'd5, 5'd5,
             '{hi: 32'd0, lo: 32'd25, tag: 5'd5, fn: 3'd0, err: 1'b0});
    repeat (3) settle();
    check("bp_cmd_rdy_full", cmd_rdy, 1'b0);
    resp_hold = 1'b0;
    repeat (5) settle();
    check("bp_wb_val", wb_val, 1'b1);
    check("bp_resp_pending", muldivresp_val, 1'b1);
    check("bp_resp_rdy", muldivresp_rdy, 1'b0);
    send_cmd(3'd0, 32'h00010000, 32'h00010000, 5'd6,
             '{hi: 32'd1, lo: 32'd0, tag: 5'd6, fn: 3'd0, err: 1'b0});
    wb_mode = 0;
    wait_drain("bp_drain");

    // reset mid-flight
    wb_mode = 1;
    send_cmd(3'd0, 32'd3, 32'd3, 5'd8,
             '{hi: 32'd0, lo: 32'd9, tag: 5'd8, fn: 3'd0, err: 1'b0});
    repeat (4) settle();
    req_mode = 1;
    send_cmd(3'd0, 32'd4, 32'd4, 5'd9,
             '{hi: 32'd0, lo: 32'd16, tag: 5'd9, fn: 3'd0, err: 1'b0});
    settle();
    check("rst_pre_req_val", muldivreq_val, 1'b1);
    check("rst_pre_wb_val", wb_val, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    req_mode = 0;
    wb_mode  = 0;
    #3;
    check_reset_outputs("midrst");

    // random
    wb_mode   = 2;
    req_mode  = 2;
    resp_rand = 1'b1;
    n_issue   = 0;
    for (int i = 0; i < 200; i++) begin
      r   = $urandom_range(0, 9);
      rfn = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0 || rb == 32'hffffffff) rb = 32'd7;
      if (rfn <= FN_DIVU) n_issue++;
      send_cmd(rfn, ra, rb, TAG_W'(i), make_exp(rfn, ra, rb, TAG_W'(i)));
    end
    wb_mode = 0;
    wait_drain("rand_drain");
    check("rand_cnt_issued", cnt_issued, 32'(n_issue));
    check("rand_cnt_done", cnt_done, 32'd200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_requester.md
# imuldiv_muldiv_requester

Initiator-side front end for the iterative mul/div unit. Accepts tagged arithmetic commands from the processor over val/rdy, issues `muldivreq` messages (fn, a, b), consumes in-order `muldivresp` results, and returns them as tagged writebacks. The block sits between decode/issue and the mul/div unit, bounds the number of in-flight operations, and completes reserved function codes locally without sending them to the unit.

## Interface
- `TAG_W`, default 5: command/writeback tag width.
- `DEPTH`, default 2: maximum number of commands accepted but not yet written back (power of 2, ≥2).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_fn` in 3: 0 = mul, 1 = div/rem signed, 2 = div/rem unsigned, 3–7 = reserved.
- `cmd_a`, `cmd_b` in 32: operands.
- `cmd_tag` in TAG_W: destination tag.
- `cmd_val` in 1, `cmd_rdy` out 1: command handshake.
- `muldivreq_msg_fn` out 3, `muldivreq_msg_a` out 32, `muldivreq_msg_b` out 32: request message.
- `muldivreq_val` out 1, `muldivreq_rdy` in 1: request handshake.
- `muldivresp_msg_result` in 64: mul gives {hi, lo} product; div gives {rem, quo}.
- `muldivresp_val` in 1, `muldivresp_rdy` out 1: response handshake.
- `wb_hi`, `wb_lo` out 32; `wb_tag` out TAG_W; `wb_fn` out 3; `wb_err` out 1.
- `wb_val` out 1, `wb_rdy` in 1: writeback handshake.
- `cnt_issued`, `cnt_done` out 32: count requests fired and writebacks fired.

## Operation
- A handshake occurs on any interface in a cycle where both val and rdy are high.
- **Command path.** A one-entry request register `req` holds {fn, a, b}. A tag queue of DEPTH entries holds {tag, fn, err}.
  - `cmd_rdy = !req_full && !tagq_full`.
  - On a command handshake, {tag, fn, err} is pushed to the tag queue. `err` = (fn > 2).
  - If `err = 0`, the command also loads `req` (`req_full = 1`).
  - If `err = 1`, `req` is not loaded and nothing is issued to the unit.
- **Request path.**
  - `muldivreq_val = req_full`, and the `msg_*` outputs come directly from `req`.
  - On a request handshake, `req_full` clears and `cnt_issued` increments.
- **Writeback register.**
  - Holds {hi, lo, tag, fn, err}; `wb_val = wb_full`.
  - It can be loaded in a cycle when `!wb_full || wb_rdy` (load-while-drain allowed).
- **Filling the writeback register** depends on the tag queue head:
  - Head with `err = 0`: `muldivresp_rdy = tagq_nonempty && (!wb_full || wb_rdy)`. On a response handshake, load `hi = result[63:32]`, `lo = result[31:0]`, the head's tag and fn, `err = 0`, then pop the head.
  - Head with `err = 1`: `muldivresp_rdy = 0`. When the writeback register can load, load `hi = lo = 0`, the head's tag and fn, `err = 1`, then pop the head. No response is consumed.
  - Tag queue empty: `muldivresp_rdy = 0`.
- **Ordering.** Writebacks leave in command order, including reserved ops. The unit responds in order, so the queue head always matches the next response.
- **Counters.** `cnt_done` increments on each writeback handshake. Both counters wrap modulo 2^32.
- **Simultaneous events.**
  - A push and a pop on the tag queue in the same cycle are both allowed when the queue is full; the pop frees the slot.
  - A command handshake in the same cycle as a request handshake is not possible, because `cmd_rdy` requires `!req_full`.
- **Reset.**
  - Clears `req_full`, `wb_full`, the tag queue pointers and count, and both counters.
  - Outputs after reset: `cmd_rdy = 1`, `muldivreq_val = 0`, `muldivresp_rdy = 0`, `wb_val = 0`, `wb_* = 0`, `cnt_* = 0`.
  - Reset asserted mid-operation drops all in-flight state. The mul/div unit is reset on the same `reset`.

## Timing
- Command handshake at cycle N → `muldivreq_val` high at N+1.
- Response handshake at cycle M → `wb_val` high at M+1.
- Reserved command accepted at N with an empty queue → `wb_val` high at N+2 (push at N, load at N+1).
- Back-to-back: while `wb_rdy` is held high, one writeback per cycle is sustained.
- Issue rate is one request per unit transaction. The block never issues a second request before `req` is taken.
- `cmd_rdy` is low for at least one cycle after each non-reserved accept.

## Structure
- Shared package `imuldiv_muldiv_pkg` holds:
  - function code constants `FN_MUL = 3'd0`, `FN_DIV = 3'd1`, `FN_DIVU = 3'd2`;
  - request message width 67 and response width 64;
  - field offsets within the request message: fn [66:64], a [63:32], b [31:0].
- Sub-module `imuldiv_muldiv_tag_queue`: a DEPTH-entry synchronous FIFO with push/pop, full/empty, and same-cycle push+pop when full.
- Request register, writeback register, and counters live in the top level.

## Test plan
- **mul:** cmd fn 0, a `0xfffffff8`, b `0x00000008`, tag 3 → request {0, `fffffff8`, `00000008`}; a model returning `ffffffff_ffffffc0` → wb hi `ffffffff`, lo `ffffffc0`, tag 3, err 0.
- **div pair:** cmd fn 1 with `0x0a01b044 / 0xffffb14a`, then fn 2 with `0xfffffff8 / 0x00000008`. Model returns `00003372_ffffdf75`, then `00000000_1fffffff` → wb in order: {hi `00003372`, lo `ffffdf75`}, then {hi 0, lo `1fffffff`}.
- **reserved:** fn 5, tag 7, placed between two muls → three writebacks in order; middle one has err 1, hi = lo = 0, tag 7; `cnt_issued = 2`, `cnt_done = 3`.
- **backpressure:**
  - hold `wb_rdy = 0` with DEPTH = 2: third command sees `cmd_rdy = 0`, and `muldivresp_rdy = 0` while the writeback register is full;
  - release `wb_rdy` → all results drain in order with no loss.
- **reset mid-flight:** assert `reset` for one cycle while a request is pending and `wb_val = 1` → next cycle all outputs at reset values, counters 0, `cmd_rdy = 1`.
- **random:** 200 random mul/div/divu/reserved commands with random `wb_rdy`/`muldivreq_rdy` stalls against a golden model → every writeback matches the model, in command order.
